// File: rtl/multicycle_control_if.sv
// Bundle of the controller's datapath-facing signals: instruction/status
// inputs in, datapath selects and enables out, plus the debug state.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       illegal_op;
    logic [3:0] state_o;

    // Controller side
    modport master (
        input  opcode, zero, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state_o
    );

    // Datapath side
    modport slave (
        output opcode, zero, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state_o
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath (lw, sw, R-type,
// beq, addi, j). Opcode is looked at only in DECODE; the lw/sw choice needed
// later in MEMADR is captured there in is_sw_reg so later opcode changes are
// ignored.
module multicycle_control #(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_reg, state_next;
    logic       is_sw_reg, is_sw_next;
    logic       mem_rdy;

    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;

    // With the handshake disabled every memory access completes in one cycle
    assign mem_rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

    // State and captured lw/sw flag; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= FETCH;
            is_sw_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            is_sw_reg <= is_sw_next;
        end
    end

    // Next-state decode and Moore outputs; everything defaults to 0
    always_comb begin
        state_next = state_reg;
        is_sw_next = is_sw_reg;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal    = 1'b0;

        case (state_reg)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_rdy;
                pc_en     = mem_rdy;
                if (mem_rdy) state_next = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                // illegal_op is the one output that looks at opcode: the
                // instruction is only known in this cycle
                case (bus.opcode)
                    OP_LW:   begin state_next = MEMADR; is_sw_next = 1'b0; end
                    OP_SW:   begin state_next = MEMADR; is_sw_next = 1'b1; end
                    OP_R:    state_next = EXECUTE;
                    OP_BEQ:  state_next = BRANCH;
                    OP_ADDI: state_next = ADDIEXEC;
                    OP_J:    state_next = JUMP;
                    default: begin state_next = FETCH; illegal = 1'b1; end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = is_sw_reg ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_rdy) state_next = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_rdy) state_next = FETCH;
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_en      = bus.zero;
                state_next = FETCH;
            end
            ADDIEXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;   // encodings 12-15: recover, outputs 0
        endcase

        // Reset is asynchronous, so the enables are also gated combinationally:
        // FETCH would otherwise follow mem_ready while reset is held
        if (!reset_n) begin
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            pc_en     = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign bus.IorD       = iord;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.RegWrite   = reg_write;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUOp      = alu_op;
    assign bus.PCSrc      = pc_src;
    assign bus.PCEn       = pc_en;
    assign bus.illegal_op = illegal;
    assign bus.state_o    = state_reg;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-path model checks every output
// on every cycle, and directed instructions check literal state traces and
// per-instruction enable counts.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    multicycle_control_if bus();

    multicycle_control #(.MEM_HANDSHAKE(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Instruction classes: 0 lw, 1 sw, 2 R, 3 beq, 4 addi, 5 j, 6 illegal
    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'b100011: return 0;
            6'b101011: return 1;
            6'b000000: return 2;
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 5;
            default:   return 6;
        endcase
    endfunction

    // States visited after DECODE for each class (-1 = back to FETCH)
    int paths [7][3] = '{'{2, 3, 4}, '{2, 5, -1}, '{6, 7, -1}, '{8, -1, -1},
                         '{9, 10, -1}, '{11, -1, -1}, '{-1, -1, -1}};

    int m_state = 0;
    int m_cls   = 6;
    int m_idx   = 0;

    // Model: walk the instruction's state path; FETCH/MEMRD/MEMWR wait on mem_ready
    always @(posedge clk or negedge reset_n) begin : model
        if (!reset_n) begin
            m_state <= 0;
            m_cls   <= 6;
            m_idx   <= 0;
        end else if (m_state == 0) begin
            if (bus.mem_ready) m_state <= 1;
        end else if (m_state == 1) begin
            m_cls   <= cls_of(bus.opcode);
            m_idx   <= 0;
            m_state <= (paths[cls_of(bus.opcode)][0] < 0) ? 0 : paths[cls_of(bus.opcode)][0];
        end else if ((m_state == 3 || m_state == 5) && !bus.mem_ready) begin
            m_state <= m_state;
        end else if (m_idx + 1 > 2) begin
            m_state <= 0;
        end else begin
            m_idx   <= m_idx + 1;
            m_state <= (paths[m_cls][m_idx + 1] < 0) ? 0 : paths[m_cls][m_idx + 1];
        end
    end

    // Expected outputs {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
    // ALUSrcB,ALUOp,PCSrc,PCEn,illegal_op,state_o} from the per-state table
    function automatic logic [18:0] exp_vec(input int st, input logic mr, input logic z,
                                            input logic rn, input logic [5:0] op);
        logic iord, mw, ir, rd, mtr, rw, sa, pc, ill;
        logic [1:0] sb, aop, ps;
        iord = 0; mw = 0; ir = 0; rd = 0; mtr = 0; rw = 0; sa = 0; pc = 0; ill = 0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            0:  begin sb = 2'b01; ir = mr; pc = mr; end
            1:  begin sb = 2'b11; ill = (cls_of(op) == 6); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  iord = 1;
            4:  begin mtr = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; aop = 2'b01; ps = 2'b01; pc = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pc = 1; end
            default: ;
        endcase
        if (!rn) begin mw = 0; ir = 0; rw = 0; pc = 0; ill = 0; end
        return {iord, mw, ir, rd, mtr, rw, sa, sb, aop, ps, pc, ill, 4'(st)};
    endfunction

    logic rec_en = 1'b0;
    int   trace[$];
    int   cnt_mw, cnt_rw, cnt_ill, cnt_wdone, cnt_pcen, cnt_aop, cnt_irw;

    // Compare process: every cycle against the model, plus per-instruction tallies
    always @(negedge clk) begin : compare
        logic [18:0] got, exp;
        got = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
               bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.PCEn, bus.illegal_op,
               bus.state_o};
        exp = exp_vec(m_state, bus.mem_ready, bus.zero, reset_n, bus.opcode);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL cycle_outputs t=%0t model_state=%0d got=%h expected=%h",
                     $time, m_state, got, exp);
        end
        if (rec_en) begin
            trace.push_back(int'(bus.state_o));
            if (bus.MemWrite) cnt_mw++;
            if (bus.RegWrite) cnt_rw++;
            if (bus.illegal_op) cnt_ill++;
            if (bus.MemWrite && bus.mem_ready) cnt_wdone++;
            if (bus.PCEn) cnt_pcen++;
            if (bus.ALUOp != 2'b00) cnt_aop++;
            if (bus.IRWrite) cnt_irw++;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
        $display("%s: got=%0h expected=%0h", name, got, exp);
    endtask

    // One instruction: per-cycle mem_ready from rdy bit i; opcode switches to
    // op_late after DECODE; trace compared as nibbles, cycle 0 in the low nibble
    task automatic apply(input string name, input logic [5:0] op, input logic z,
                         input logic [15:0] rdy, input int n, input logic [5:0] op_late,
                         input logic [63:0] exp_tr);
        logic [63:0] got_tr;
        trace.delete();
        cnt_mw = 0; cnt_rw = 0; cnt_ill = 0; cnt_wdone = 0;
        cnt_pcen = 0; cnt_aop = 0; cnt_irw = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.opcode    = (i < 2) ? op : op_late;
            bus.zero      = z;
            bus.mem_ready = rdy[i];
            rec_en        = 1'b1;
        end
        @(negedge clk); #1;
        rec_en = 1'b0;
        got_tr = '0;
        for (int k = 0; k < trace.size() && k < 16; k++) got_tr[4*k +: 4] = 4'(trace[k]);
        check({name, "_len"}, 64'(trace.size()), 64'(n));
        check({name, "_trace"}, got_tr, exp_tr);
    endtask

    initial begin
        bus.opcode = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        // Reset held with mem_ready high: no enables, FETCH
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_irwrite", 64'(bus.IRWrite), 64'd0);
        check("rst_pcen", 64'(bus.PCEn), 64'd0);
        check("rst_state", 64'(bus.state_o), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.mem_ready = 1'b0;

        // lw, opcode switched to sw after DECODE must not matter
        apply("lw", 6'b100011, 1'b0, 16'b011111, 6, 6'b101011, 64'h043210);
        check("lw_regwrite_cycles", 64'(cnt_rw), 64'd1);
        check("lw_aluop_nonzero", 64'(cnt_aop), 64'd0);

        apply("r_add", 6'b000000, 1'b0, 16'b01111, 5, 6'b000000, 64'h07610);
        check("r_regwrite_cycles", 64'(cnt_rw), 64'd1);
        check("r_aluop_cycles", 64'(cnt_aop), 64'd1);

        apply("beq_taken", 6'b000100, 1'b1, 16'b0111, 4, 6'b000100, 64'h0810);
        check("beq_taken_pcen", 64'(cnt_pcen), 64'd2);
        check("beq_taken_aluop", 64'(cnt_aop), 64'd1);
        apply("beq_not", 6'b000100, 1'b0, 16'b0111, 4, 6'b000100, 64'h0810);
        check("beq_not_pcen", 64'(cnt_pcen), 64'd1);

        apply("addi", 6'b001000, 1'b0, 16'b01111, 5, 6'b001000, 64'h0A910);
        apply("j", 6'b000010, 1'b0, 16'b0111, 4, 6'b000010, 64'h0B10);

        // sw with memory stalling 3 cycles in MEMWR
        apply("sw_wait", 6'b101011, 1'b0, 16'h0047, 8, 6'b101011, 64'h05555210);
        check("sw_memwrite_cycles", 64'(cnt_mw), 64'd4);
        check("sw_write_done", 64'(cnt_wdone), 64'd1);

        // instruction fetch stalled for 2 cycles
        apply("fetch_wait", 6'b000010, 1'b0, 16'b011100, 6, 6'b000010, 64'h0B1000);
        check("fetch_wait_irwrite", 64'(cnt_irw), 64'd1);

        apply("illegal", 6'b111111, 1'b0, 16'b011, 3, 6'b111111, 64'h010);
        check("illegal_pulses", 64'(cnt_ill), 64'd1);
        check("illegal_regwrite", 64'(cnt_rw), 64'd0);
        check("illegal_memwrite", 64'(cnt_mw), 64'd0);

        // Asynchronous reset in the middle of a stalled store
        apply("sw_abort", 6'b101011, 1'b0, 16'b00111, 5, 6'b101011, 64'h55210);
        check("abort_memwrite_before", 64'(bus.MemWrite), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_memwrite_after", 64'(bus.MemWrite), 64'd0);
        check("abort_state", 64'(bus.state_o), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.mem_ready = 1'b0;
        apply("resume_j", 6'b000010, 1'b0, 16'b0111, 4, 6'b000010, 64'h0B10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
